// File: rtl/mul_seq_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
// State encodings, default operand width and buzzer tone values.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int W_DEF = 4;

    localparam logic [7:0] BZ_TONE = 8'h10;
    localparam logic [7:0] BZ_ZERO = 8'h40;

endpackage

// File: rtl/mul_seq_if.sv
// Sequencer <-> shift-add multiplier link.
// master drives load/operands, slave returns the product.
interface mul_seq_if #(
    parameter int W = 4
);
    logic           ld;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] ry;

    modport master (output ld, output a, output b, input ry);
    modport slave  (input ld, input a, input b, output ry);
endinterface

// File: rtl/mul_seq_rise_det.sv
// Synchronous 1-bit rising-edge detector.
// History resets high so a level held through reset never fires.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 1'b1;
        end else begin
            hist <= d;
        end
    end

    assign rise = d & ~hist;

endmodule

// File: rtl/mul_seq.sv
// Sequencer for the shift-add multiplier: load, W run steps, capture.
// Optional buzzer outputs (bz_wr/bz_val) under `define MUL_SEQ_BZ_EN.
import mul_seq_pkg::*;

module mul_seq #(
    parameter int W     = W_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    mul_seq_if.master        mul,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
`ifdef MUL_SEQ_BZ_EN
    output logic             bz_wr,
    output logic [7:0]       bz_val,
`endif
    output logic [CNT_W-1:0] op_cnt
);

    localparam int SW = (W > 1) ? $clog2(W) : 1;
    localparam logic [SW-1:0] LAST = SW'(W - 1);

    state_t        state;
    logic [SW-1:0] step;
    logic          rise;

    rise_det u_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (start),
        .rise (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            step   <= '0;
            mul.ld <= 1'b1;
            mul.a  <= '0;
            mul.b  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rise) begin
                        mul.a <= a;
                        mul.b <= b;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mul.ld <= 1'b0;
                    step   <= '0;
                    state  <= ST_RUN;
                end
                ST_RUN: begin
                    if (step == LAST) begin
                        mul.ld <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= mul.ry;
                        op_cnt <= op_cnt + 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MUL_SEQ_BZ_EN
    // Tone chosen from the product being captured in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bz_wr  <= 1'b0;
            bz_val <= 8'h00;
        end else begin
            bz_wr <= 1'b0;
            if (state == ST_RUN && step == LAST) begin
                bz_wr  <= 1'b1;
                bz_val <= (mul.ry == '0) ? BZ_ZERO : BZ_TONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq.
// Define MUL_SEQ_BZ_EN to also check the buzzer outputs.
module tb_mul_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] op_cnt;
`ifdef MUL_SEQ_BZ_EN
    logic       bz_wr;
    logic [7:0] bz_val;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_cnt;

    mul_seq_if #(.W(4)) mif ();

    // Idealised multiplier: product once loading has finished.
    assign mif.ry = mif.ld ? 8'h00 : ({4'b0, mif.a} * {4'b0, mif.b});

    mul_seq #(.W(4), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .mul    (mif),
        .busy   (busy),
        .done   (done),
        .result (result),
`ifdef MUL_SEQ_BZ_EN
        .bz_wr  (bz_wr),
        .bz_val (bz_val),
`endif
        .op_cnt (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [3:0] oa, input logic [3:0] ob,
                          input logic [7:0] exp_res);
        a = oa;
        b = ob;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("busy", busy, (k <= 5));
            chk("mul_ld", mif.ld, !(k >= 2 && k <= 5));
            chk("done", done, (k == 6));
            if (k == 2) start = 1'b0;
            if (k == 3) begin
                chk("mul_a", mif.a, oa);
                chk("mul_b", mif.b, ob);
            end
`ifdef MUL_SEQ_BZ_EN
            chk("bz_wr", bz_wr, (k == 6));
`endif
        end
        exp_cnt = exp_cnt + 8'd1;
        chk("result", result, exp_res);
        chk("op_cnt", op_cnt, exp_cnt);
`ifdef MUL_SEQ_BZ_EN
        chk("bz_val", bz_val, (exp_res == 8'h00) ? 8'h40 : 8'h10);
`endif
    endtask

    int dones;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_op_cnt", op_cnt, 8'h00);
        chk("rst_mul_ld", mif.ld, 1'b1);
        chk("rst_mul_a", mif.a, 4'h0);
`ifdef MUL_SEQ_BZ_EN
        chk("rst_bz_wr", bz_wr, 1'b0);
        chk("rst_bz_val", bz_val, 8'h00);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op(4'd13, 4'd11, 8'h8F);
        @(negedge clk);
        chk("idle_after", busy, 1'b0);

        run_op(4'd15, 4'd15, 8'hE1);
        run_op(4'd0, 4'd9, 8'h00);
        run_op(4'd3, 4'd3, 8'h09);
        run_op(4'd0, 4'd5, 8'h00);
        @(negedge clk);

        // Operand change and start pulse while running are ignored.
        a = 4'd7;
        b = 4'd6;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1;
        b = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_mul_a", mif.a, 4'd7);
        chk("mid_mul_b", mif.b, 4'd6);
        @(negedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        chk("mid_done", done, 1'b1);
        chk("mid_result", result, 8'h2A);
        chk("mid_op_cnt", op_cnt, exp_cnt);
        @(negedge clk);
        chk("mid_no_retrig", busy, 1'b0);

        // Start held high for 20 cycles gives one op.
        dones = 0;
        start = 1'b1;
        a = 4'd2;
        b = 4'd4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("hold_dones", dones, 1);
        chk("hold_op_cnt", op_cnt, exp_cnt);
        chk("hold_result", result, 8'h08);

        // Reset during RUN aborts.
        @(negedge clk);
        a = 4'd9;
        b = 4'd9;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("pre_abort_ld", mif.ld, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 8'h00);
        chk("abort_op_cnt", op_cnt, 8'h00);
        chk("abort_ld", mif.ld, 1'b1);
        exp_cnt = 8'd0;

        // Start high across reset release never fires.
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || done) dones++;
        end
        chk("rst_hold_noop", dones, 0);
        chk("rst_hold_cnt", op_cnt, 8'h00);
        start = 1'b0;
        @(negedge clk);

        // 256 back-to-back ops wrap the counter.
        for (int i = 0; i < 256; i++) begin
            logic [3:0] x;
            logic [3:0] y;
            x = 4'(i);
            y = 4'(i >> 4);
            run_op(x, y, {4'b0, x} * {4'b0, y});
        end
        chk("wrap_op_cnt", op_cnt, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
